// File: rtl/rom_row_loader.sv
// rtl/rom_row_loader.sv - ROM-to-row-buffer loader feeding the CNN front end
//
// Purpose: reads one image row of IM_SIZE words at a time from the sample
// ROM into a parallel row buffer and presents each completed row downstream
// with a valid/ready handshake. It walks all NUM_ROWS rows of the selected
// sample, pulses frame_done after the last row is accepted, and can step to
// the next sample at any time.
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   en            fetch enable, low stalls ROM address issue
//   next_sample   step sample_sel and abort the current frame
//   rom_data      ROM read data, valid one cycle after rom_addr
//   rom_addr      ROM read address
//   sample_sel    selected sample (ROM bank select)
//   row_data      row buffer, word k at [k*DATA_W +: DATA_W]
//   row_valid     row_data holds a complete row
//   row_ready     downstream accepts the presented row
//   row_idx       row held in row_data / being fetched
//   frame_done    one-cycle pulse after the last row is accepted
//   busy          high whenever the loader is not idle
module rom_row_loader #(
    parameter int DATA_W   = 32,
    parameter int IM_SIZE  = 32,
    parameter int NUM_ROWS = 32,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 4,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int IDX_W   = (IM_SIZE > 1) ? $clog2(IM_SIZE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      next_sample,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [SAMPLE_W-1:0]       sample_sel,
    output logic [DATA_W*IM_SIZE-1:0] row_data,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [ROW_W-1:0]          row_idx,
    output logic                      frame_done,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;

    logic [ADDR_W-1:0]           r_rom_addr;
    logic [SAMPLE_W-1:0]         r_sample_sel;
    logic [ROW_W-1:0]            r_row_idx;
    logic                        r_row_valid;
    logic [DATA_W*IM_SIZE-1:0]   r_row_data;
    logic [IDX_W-1:0]            r_issue_cnt;
    // Capture pipeline: one entry tracking the word issued last cycle.
    logic                        r_cap_valid;
    logic [IDX_W-1:0]            r_cap_idx;

    logic                        w_issue;
    logic                        w_last_issue;
    logic                        w_handshake;
    logic                        w_last_row;

    assign w_issue      = (r_state == S_FETCH) && en;
    assign w_last_issue = w_issue && (r_issue_cnt == IDX_W'(IM_SIZE - 1));
    assign w_handshake  = (r_state == S_PRESENT) && r_row_valid && row_ready;
    assign w_last_row   = (r_row_idx == ROW_W'(NUM_ROWS - 1));

    // State register; next_sample overrides the FSM and parks it in IDLE.
    always_ff @(posedge clk) begin
        if (rst || next_sample) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (en) w_next_state = S_FETCH;
            S_FETCH:   if (w_last_issue) w_next_state = S_DRAIN;
            S_DRAIN:   w_next_state = S_PRESENT;
            S_PRESENT: if (w_handshake) w_next_state = w_last_row ? S_DONE : S_FETCH;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (r_state != S_IDLE);
        frame_done = (r_state == S_DONE);
    end

    // Datapath: address walk, capture pipeline, row bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr   <= '0;
            r_sample_sel <= '0;
            r_row_idx    <= '0;
            r_row_valid  <= 1'b0;
            r_row_data   <= '0;
            r_issue_cnt  <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_idx    <= '0;
        end else if (next_sample) begin
            // Abort: the in-flight word is dropped by clearing r_cap_valid.
            r_sample_sel <= r_sample_sel + SAMPLE_W'(1);
            r_rom_addr   <= '0;
            r_row_idx    <= '0;
            r_row_valid  <= 1'b0;
            r_issue_cnt  <= '0;
            r_cap_valid  <= 1'b0;
        end else begin
            r_cap_valid <= w_issue;
            r_cap_idx   <= r_issue_cnt;

            // The word issued last cycle lands in its issue-order slot.
            if (r_cap_valid) begin
                for (int k = 0; k < IM_SIZE; k++) begin
                    if (r_cap_idx == IDX_W'(k)) begin
                        r_row_data[k*DATA_W +: DATA_W] <= rom_data;
                    end
                end
            end

            case (r_state)
                S_FETCH: begin
                    if (en) begin
                        r_rom_addr  <= r_rom_addr + ADDR_W'(1);
                        r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_row_valid <= 1'b1;
                end
                S_PRESENT: begin
                    // rom_addr already sits on the next row base here.
                    if (w_handshake) begin
                        r_row_valid <= 1'b0;
                        if (!w_last_row) begin
                            r_row_idx <= r_row_idx + ROW_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_rom_addr <= '0;
                    r_row_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rom_addr   = r_rom_addr;
    assign sample_sel = r_sample_sel;
    assign row_data   = r_row_data;
    assign row_valid  = r_row_valid;
    assign row_idx    = r_row_idx;

endmodule
